// File: rtl/muldiv_hilo_unit.sv
// HI/LO register file with single-cycle multiply, MT/MF moves and a
// multi-cycle restoring radix-2 divider that stalls the pipeline while busy.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       aluop_i,
    input  logic [WIDTH-1:0] reg1_i,
    input  logic [WIDTH-1:0] reg2_i,
    input  logic             annul_i,
    output logic             stallreq_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        RUN     = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic             div_zero;
    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic             neg_q, neg_r;

    logic                      is_div, is_signed_div, div_start;
    logic [WIDTH:0]            shifted, diff;
    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]        prod_u;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    assign is_div        = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    assign is_signed_div = (aluop_i == EXE_DIV_OP);
    assign div_start     = (state == IDLE) && is_div && !annul_i && !rst;

    // Operands are sign-extended to full product width so the low 2*WIDTH bits are exact.
    assign prod_s = $signed({{WIDTH{reg1_i[WIDTH-1]}}, reg1_i})
                  * $signed({{WIDTH{reg2_i[WIDTH-1]}}, reg2_i});
    assign prod_u = {{WIDTH{1'b0}}, reg1_i} * {{WIDTH{1'b0}}, reg2_i};

    // Restoring step: bring the next dividend bit into the partial remainder.
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};

    always_comb begin
        state_nxt  = state;
        stallreq_o = 1'b0;
        if (rst) begin
            state_nxt  = IDLE;
        end else if (annul_i) begin
            state_nxt  = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (is_div) begin
                        stallreq_o = 1'b1;
                        state_nxt  = (reg2_i == '0) ? DIVZERO : RUN;
                    end
                end
                RUN: begin
                    stallreq_o = 1'b1;
                    if (cnt == LAST_ITER) state_nxt = DONE;
                end
                DIVZERO: begin
                    stallreq_o = 1'b1;
                    state_nxt  = DONE;
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            div_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == RUN) cnt <= cnt + CW'(1);
            else              cnt <= '0;
            if (div_start) div_zero <= (reg2_i == '0);
        end
    end

    // Divider datapath; meaningful only while the FSM is in RUN/DONE.
    always_ff @(posedge clk) begin
        if (div_start) begin
            rem   <= '0;
            quo   <= magnitude(reg1_i, is_signed_div);
            dvs   <= magnitude(reg2_i, is_signed_div);
            neg_q <= is_signed_div && (reg1_i[WIDTH-1] ^ reg2_i[WIDTH-1]);
            neg_r <= is_signed_div && reg1_i[WIDTH-1];
        end else if (state == RUN) begin
            rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (!annul_i) begin
            if (state == DONE) begin
                if (!div_zero) begin
                    hi <= apply_sign(rem, neg_r);
                    lo <= apply_sign(quo, neg_q);
                end
            end else begin
                case (aluop_i)
                    EXE_MULT_OP:  {hi, lo} <= prod_s;
                    EXE_MULTU_OP: {hi, lo} <= prod_u;
                    EXE_MTHI_OP:  hi <= reg1_i;
                    EXE_MTLO_OP:  lo <= reg1_i;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        result_o = '0;
        if (aluop_i == EXE_MFHI_OP)      result_o = hi;
        else if (aluop_i == EXE_MFLO_OP) result_o = lo;
    end

    assign hi_o = hi;
    assign lo_o = lo;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Bench for muldiv_hilo_unit: directed and randomized HI/LO operations
// checked against an arithmetic model of HI/LO and expected stall lengths.
module tb_muldiv_hilo_unit;

    localparam logic [7:0] NOP   = 8'h00;
    localparam logic [7:0] MFHI  = 8'b0001_0000;
    localparam logic [7:0] MTHI  = 8'b0001_0001;
    localparam logic [7:0] MFLO  = 8'b0001_0010;
    localparam logic [7:0] MTLO  = 8'b0001_0011;
    localparam logic [7:0] MULT  = 8'b0001_1000;
    localparam logic [7:0] MULTU = 8'b0001_1001;
    localparam logic [7:0] DIV   = 8'b0001_1010;
    localparam logic [7:0] DIVU  = 8'b0001_1011;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop;
    logic [31:0] reg1, reg2;
    logic        annul;
    logic        stallreq;
    logic [31:0] result, hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] hi_m, lo_m;

    muldiv_hilo_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop),
        .reg1_i     (reg1),
        .reg2_i     (reg2),
        .annul_i    (annul),
        .stallreq_o (stallreq),
        .result_o   (result),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    always #5 clk = ~clk;

    // Reference: what HI/LO become after an op, from arithmetic definitions.
    function automatic void model_op(input logic [7:0] op, input logic [31:0] a, b,
                                     inout logic [31:0] h, l);
        longint          sa, sb, q, r;
        longint unsigned p;
        case (op)
            MULT: begin
                p = longint'(longint'($signed(a)) * longint'($signed(b)));
                h = p[63:32]; l = p[31:0];
            end
            MULTU: begin
                p = longint'(a) * longint'(b);
                h = p[63:32]; l = p[31:0];
            end
            MTHI: h = a;
            MTLO: l = a;
            DIVU: if (b != 0) begin
                l = a / b; h = a % b;
            end
            DIV: if (b != 0) begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                q = sa / sb; r = sa % sb;
                l = q[31:0]; h = r[31:0];
            end
            default: ;
        endcase
    endfunction

    task automatic count_stall(output int n);
        n = 0;
        while (stallreq === 1'b1 && n < 200) begin
            n++;
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; annul = 1'b0; aluop = DIV; reg1 = 32'd50; reg2 = 32'd5;
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if (stallreq !== 1'b0) begin
            errors++; $display("FAIL reset_stall got %b want 0", stallreq);
        end
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo);
        end
        aluop = NOP;
        @(negedge clk);
        rst = 1'b0;
        hi_m = 32'h0; lo_m = 32'h0;
    endtask

    task automatic test_simple_op(input logic [7:0] op, input logic [31:0] a, b);
        @(negedge clk);
        aluop = op; reg1 = a; reg2 = b; #1;
        checks++;
        if (stallreq !== 1'b0) begin
            errors++; $display("FAIL simple_stall op %h got %b want 0", op, stallreq);
        end
        model_op(op, a, b, hi_m, lo_m);
        @(negedge clk);
        aluop = (op == MTLO) ? MFLO : MFHI; #1;
        checks++;
        if (hi !== hi_m || lo !== lo_m) begin
            errors++; $display("FAIL simple_hilo op %h got %h/%h want %h/%h", op, hi, lo, hi_m, lo_m);
        end
        checks++;
        if (result !== ((op == MTLO) ? lo_m : hi_m)) begin
            errors++; $display("FAIL mf_after_write op %h got %h", op, result);
        end
        aluop = NOP;
    endtask

    task automatic test_div_one(input logic [7:0] op, input logic [31:0] a, b);
        int n;
        int exp_n;
        exp_n = (b == 0) ? 2 : 33;
        model_op(op, a, b, hi_m, lo_m);
        @(negedge clk);
        aluop = op; reg1 = a; reg2 = b; #1;
        count_stall(n);
        checks++;
        if (n !== exp_n) begin
            errors++; $display("FAIL div_stall_len %h/%h got %0d want %0d", a, b, n, exp_n);
        end
        aluop = NOP;
        @(negedge clk); #1;
        checks++;
        if (hi !== hi_m || lo !== lo_m) begin
            errors++; $display("FAIL div_result %h/%h got %h/%h want %h/%h", a, b, hi, lo, hi_m, lo_m);
        end
        checks++;
        if (stallreq !== 1'b0) begin
            errors++; $display("FAIL div_idle_stall got %b want 0", stallreq);
        end
    endtask

    task automatic test_mult;
        test_simple_op(MULT, 32'hFFFF_FFFE, 32'd3);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
            errors++; $display("FAIL mult_plan got %h/%h want ffffffff/fffffffa", hi, lo);
        end
        test_simple_op(MULTU, 32'hFFFF_FFFE, 32'd3);
        checks++;
        if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin
            errors++; $display("FAIL multu_plan got %h/%h want 00000002/fffffffa", hi, lo);
        end
    endtask

    task automatic test_divide;
        test_div_one(DIVU, 32'd100, 32'd7);
        checks++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            errors++; $display("FAIL divu_plan got %h/%h want 2/14", hi, lo);
        end
        test_div_one(DIV, 32'hFFFF_FFF9, 32'd2);
        checks++;
        if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div_neg got %h/%h want ffffffff/fffffffd", hi, lo);
        end
        test_div_one(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++;
        if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
            errors++; $display("FAIL div_wrap got %h/%h want 0/80000000", hi, lo);
        end
        test_div_one(DIV, 32'd7, 32'hFFFF_FFFE);
    endtask

    task automatic test_divzero;
        test_simple_op(MTHI, 32'h11, 32'h0);
        test_simple_op(MTLO, 32'h22, 32'h0);
        test_div_one(DIV, 32'd5, 32'd0);
        @(negedge clk);
        aluop = MFHI; #1;
        checks++;
        if (result !== 32'h11) begin
            errors++; $display("FAIL mfhi got %h want 11", result);
        end
        aluop = MFLO; #1;
        checks++;
        if (result !== 32'h22) begin
            errors++; $display("FAIL mflo got %h want 22", result);
        end
        aluop = NOP; #1;
        checks++;
        if (result !== 32'h0) begin
            errors++; $display("FAIL result_nonmf got %h want 0", result);
        end
    endtask

    task automatic test_annul;
        @(negedge clk);
        aluop = DIVU; reg1 = 32'd12345; reg2 = 32'd7; #1;
        checks++;
        if (stallreq !== 1'b1) begin
            errors++; $display("FAIL annul_start_stall got %b want 1", stallreq);
        end
        for (int i = 0; i < 10; i++) @(negedge clk);
        annul = 1'b1; aluop = NOP; #1;
        checks++;
        if (stallreq !== 1'b0) begin
            errors++; $display("FAIL annul_stall got %b want 0", stallreq);
        end
        @(negedge clk);
        annul = 1'b0; #1;
        checks++;
        if (hi !== hi_m || lo !== lo_m || stallreq !== 1'b0) begin
            errors++; $display("FAIL annul_hilo got %h/%h/%b want %h/%h/0", hi, lo, stallreq, hi_m, lo_m);
        end
        @(negedge clk);
        annul = 1'b1; aluop = MULT; reg1 = 32'd9; reg2 = 32'd9;
        @(negedge clk);
        annul = 1'b0; aluop = NOP; #1;
        checks++;
        if (hi !== hi_m || lo !== lo_m) begin
            errors++; $display("FAIL annul_mult got %h/%h want %h/%h", hi, lo, hi_m, lo_m);
        end
        test_simple_op(MTLO, 32'h5, 32'h0);
        checks++;
        if (lo !== 32'h5) begin
            errors++; $display("FAIL annul_mtlo got %h want 5", lo);
        end
    endtask

    task automatic test_rst_mid;
        @(negedge clk);
        aluop = DIVU; reg1 = 32'd1000; reg2 = 32'd3;
        for (int i = 0; i < 6; i++) @(negedge clk);
        rst = 1'b1; #1;
        checks++;
        if (stallreq !== 1'b0) begin
            errors++; $display("FAIL rst_mid_stall got %b want 0", stallreq);
        end
        @(negedge clk);
        rst = 1'b0; aluop = NOP; #1;
        hi_m = 32'h0; lo_m = 32'h0;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || stallreq !== 1'b0) begin
            errors++; $display("FAIL rst_mid_state got %h/%h/%b want 0/0/0", hi, lo, stallreq);
        end
        test_div_one(DIVU, 32'd9, 32'd3);
        checks++;
        if (lo !== 32'd3 || hi !== 32'd0) begin
            errors++; $display("FAIL rst_mid_div got %h/%h want 0/3", hi, lo);
        end
    endtask

    task automatic test_back_to_back;
        int n1, n2;
        logic [31:0] h1, l1;
        model_op(DIVU, 32'd1000, 32'd33, hi_m, lo_m);
        h1 = hi_m; l1 = lo_m;
        @(negedge clk);
        aluop = DIVU; reg1 = 32'd1000; reg2 = 32'd33; #1;
        count_stall(n1);
        aluop = DIV; reg1 = 32'hFFFF_FC18; reg2 = 32'd7; #1;
        checks++;
        if (n1 !== 33 || stallreq !== 1'b0) begin
            errors++; $display("FAIL b2b_first got %0d/%b want 33/0", n1, stallreq);
        end
        @(negedge clk); #1;
        checks++;
        if (stallreq !== 1'b1 || hi !== h1 || lo !== l1) begin
            errors++; $display("FAIL b2b_restart got %b %h/%h want 1 %h/%h", stallreq, hi, lo, h1, l1);
        end
        count_stall(n2);
        model_op(DIV, 32'hFFFF_FC18, 32'd7, hi_m, lo_m);
        aluop = NOP;
        @(negedge clk); #1;
        checks++;
        if (n2 !== 33 || hi !== hi_m || lo !== lo_m) begin
            errors++; $display("FAIL b2b_second got %0d %h/%h want 33 %h/%h", n2, hi, lo, hi_m, lo_m);
        end
    endtask

    task automatic test_random;
        logic [7:0]  ops [6];
        logic [7:0]  op;
        logic [31:0] a, b;
        ops[0] = MULT; ops[1] = MULTU; ops[2] = MTHI;
        ops[3] = MTLO; ops[4] = DIV;   ops[5] = DIVU;
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(5)];
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(3) == 0) b = b >> $urandom_range(31);
            if ($urandom_range(7) == 0) b = 32'h0;
            if (op == DIV || op == DIVU) test_div_one(op, a, b);
            else                         test_simple_op(op, a, b);
        end
    endtask

    initial begin
        rst = 1'b1; annul = 1'b0; aluop = NOP; reg1 = '0; reg2 = '0;
        test_reset;
        test_mult;
        test_divide;
        test_divzero;
        test_annul;
        test_rst_mid;
        test_back_to_back;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- EX-stage consumer of the decoder's HI/LO-class operations: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- Holds the architectural HI/LO registers.
- Runs a multi-cycle radix-2 divider and raises a stall request that freezes PC/IF/ID/EX while a divide is in flight.
- Sits beside the EX ALU. Its operands arrive already forwarded from the decode stage.

Parameters:
WIDTH, 32, operand/HI/LO width; divider iteration count equals WIDTH.

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset; synchronous, active-high
aluop_i  in  8  ALU op code (AluOpBus encodings: EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP, EXE_MTHI_OP, EXE_MTLO_OP, EXE_MFHI_OP, EXE_MFLO_OP; all others ignored)
reg1_i  in  WIDTH  operand 1 (rs; dividend / multiplicand / MT source)
reg2_i  in  WIDTH  operand 2 (rt; divisor / multiplier)
annul_i  in  1  pipeline flush; aborts the in-flight divide
stallreq_o  out  1  stall request to the pipeline controller
result_o  out  WIDTH  GPR write data for MFHI/MFLO; 0 otherwise
hi_o  out  WIDTH  architectural HI
lo_o  out  WIDTH  architectural LO

Behaviour:
Reset (synchronous, rst=1 at a clock edge):
- hi_o=0, lo_o=0, FSM=IDLE, iteration counter=0.
- stallreq_o=0 combinationally while rst=1.
- Overrides every other input, including mid-divide; the partial result is discarded.

MULT/MULTU:
- 64-bit product. Signed or unsigned per op.
- Written at the next edge: HI<=prod[63:32], LO<=prod[31:0].
- No stall.

MTHI/MTLO:
- HI or LO <= reg1_i at the next edge. The other register is unchanged.
- No stall.

MFHI/MFLO:
- result_o = current registered HI/LO, combinationally.
- An MF in the cycle after MULT/MT sees the new value, because the write has already occurred.

Divide FSM (states IDLE, DIVZERO, RUN, DONE):
- IDLE, aluop_i=DIV/DIVU, annul_i=0:
  - stallreq_o=1 combinationally.
  - If reg2_i==0, go to DIVZERO.
  - Otherwise latch the operand magnitudes and sign flags (signed op only), clear the counter, go to RUN.
- RUN: one restoring subtract-shift per cycle for WIDTH cycles. stallreq_o=1. On counter==WIDTH-1, go to DONE.
- DIVZERO: stallreq_o=1 for one cycle, then go to DONE.
- DONE:
  - stallreq_o=0.
  - At the edge, HI<=remainder and LO<=quotient, then go to IDLE.
  - Divide-by-zero: HI/LO are left unchanged.
- Stall lengths:
  - Normal divide: WIDTH+1 cycles of stallreq (IDLE cycle plus 32 RUN cycles), then one DONE cycle with stallreq_o=0.
  - Divide-by-zero: 2 stall cycles.
- aluop_i/reg1_i/reg2_i are held stable by the pipeline while stallreq_o=1. The unit does not re-sample them after IDLE.
- No restart: DONE always returns to IDLE. The next op is evaluated in IDLE on the following cycle, so back-to-back DIVs each take the full sequence.

Signed divide:
- Quotient is negated if the operand signs differ.
- Remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wrap, no trap).

Flush:
- annul_i=1 in any state: FSM goes to IDLE at the edge, no HI/LO write, stallreq_o forced to 0 combinationally.
- annul_i also suppresses same-cycle MULT/MT writes.

Priority: rst > annul_i > op.

Test Plan:
- Reset, then MULT reg1=0xFFFFFFFE (-2), reg2=3 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with same operands -> HI=0x00000002, LO=0xFFFFFFFA; stallreq never asserted.
- DIVU 100/7 -> stallreq high exactly 33 cycles, low in DONE cycle, then LO=14, HI=2; pipeline holds operands throughout.
- DIV -7/2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload HI=0x11, LO=0x22 via MTHI/MTLO; DIV 5/0 -> stallreq high 2 cycles, HI/LO still 0x11/0x22; MFHI -> result_o=0x11, MFLO -> result_o=0x22.
- DIVU started, annul_i pulsed at RUN cycle 10 -> stallreq drops the same cycle, HI/LO unchanged, a following MTLO 0x5 writes LO=5 normally.
- rst asserted mid-RUN -> next cycle HI=LO=0, stallreq=0, FSM idle; a subsequent DIVU 9/3 completes with LO=3, HI=0.
